// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - mask encodings and FSM state type for the MEM stage
package mem_pkg;

  localparam logic [1:0] MASK_BYTE = 2'd0;
  localparam logic [1:0] MASK_HALF = 2'd1;
  localparam logic [1:0] MASK_WORD = 2'd2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } memState_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store byte-lane placement and load extract/extend
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  maskMode,
  input  logic [1:0]  byteOff,
  input  logic        sext,
  input  logic [31:0] storeData,
  input  logic [31:0] rdata,
  output logic [3:0]  byteEn,
  output logic [31:0] wdata,
  output logic [31:0] loadData
);

  logic [31:0] shifted;

  assign shifted = rdata >> {byteOff, 3'b000};

  // maskMode 3 falls through to the word case
  always_comb begin
    byteEn   = 4'hF;
    wdata    = storeData;
    loadData = shifted;
    case (maskMode)
      MASK_BYTE: begin
        byteEn   = 4'b0001 << byteOff;
        wdata    = {4{storeData[7:0]}};
        loadData = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
      MASK_HALF: begin
        byteEn   = 4'b0011 << byteOff;
        wdata    = {2{storeData[15:0]}};
        loadData = {{16{sext & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        byteEn   = 4'hF;
        wdata    = storeData;
        loadData = shifted;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: data-memory bus FSM, timeout and MEM/WB register
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_mem_ctrl_memRead,
  input  logic        in_mem_ctrl_memWrite,
  input  logic [1:0]  in_mem_ctrl_maskMode,
  input  logic        in_mem_ctrl_sext,
  input  logic        in_wb_ctrl_toReg,
  input  logic        in_wb_ctrl_regWrite,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        misalign,
  output logic        bus_err,
  output logic [31:0] out_wb_data,
  output logic [4:0]  out_rd,
  output logic        out_wb_ctrl_regWrite
);

  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);

  memState_t       state, stateNext;
  logic [CntW-1:0] count, countNext;
  logic            access, misaligned, misalignPulse;
  logic            reqInt, abort, stall;
  logic [31:0]     loadData;

  assign access = in_mem_ctrl_memRead | in_mem_ctrl_memWrite;

  always_comb begin
    misaligned = 1'b0;
    case (in_mem_ctrl_maskMode)
      MASK_BYTE: misaligned = 1'b0;
      MASK_HALF: misaligned = in_alu_result[0];
      default:   misaligned = |in_alu_result[1:0];
    endcase
  end

  mem_lane_align u_lane (
    .maskMode (in_mem_ctrl_maskMode),
    .byteOff  (in_alu_result[1:0]),
    .sext     (in_mem_ctrl_sext),
    .storeData(in_store_data),
    .rdata    (dmem_rdata),
    .byteEn   (dmem_be),
    .wdata    (dmem_wdata),
    .loadData (loadData)
  );

  assign dmem_we   = in_mem_ctrl_memWrite;
  assign dmem_addr = {in_alu_result[31:2], 2'b00};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= stateNext;
      count <= countNext;
    end
  end

  // Ready wins over timeout when both land on the last wait cycle
  always_comb begin
    stateNext = state;
    countNext = count;
    reqInt    = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE: begin
        if (access && !misaligned) begin
          reqInt = 1'b1;
          if (!dmem_ready) begin
            stateNext = S_WAIT;
            countNext = CntW'(1);
          end
        end
      end
      S_WAIT: begin
        reqInt = 1'b1;
        if (dmem_ready) begin
          stateNext = S_IDLE;
          countNext = '0;
        end else if (count == CntW'(TIMEOUT_CYCLES)) begin
          abort     = 1'b1;
          stateNext = S_IDLE;
          countNext = '0;
        end else begin
          countNext = count + 1'b1;
        end
      end
      default: begin
        stateNext = S_IDLE;
        countNext = '0;
      end
    endcase
  end

  assign misalignPulse = (state == S_IDLE) & access & misaligned;
  assign stall         = reqInt & ~dmem_ready & ~abort;

  assign dmem_req  = reqInt & reset_n;
  assign mem_stall = stall & reset_n;
  assign misalign  = misalignPulse & reset_n;
  assign bus_err   = abort & reset_n;

  // A stalled edge inserts a bubble; data and rd keep their last value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_wb_data          <= '0;
      out_rd               <= '0;
      out_wb_ctrl_regWrite <= 1'b0;
    end else if (stall) begin
      out_wb_ctrl_regWrite <= 1'b0;
    end else begin
      out_wb_data          <= in_wb_ctrl_toReg ? loadData : in_alu_result;
      out_rd               <= in_rd;
      out_wb_ctrl_regWrite <= in_wb_ctrl_regWrite & ~misalignPulse & ~abort;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - vector, sequence and random checks for mem_access_stage
module tb_mem_access_stage;

  localparam int TMO = 4;

  logic        clk, reset_n;
  logic        memRead, memWrite, sext, toReg, regWrite;
  logic [1:0]  maskMode;
  logic [31:0] aluResult, storeData;
  logic [4:0]  rdIn;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall, misalign, bus_err;
  logic [31:0] out_wb_data;
  logic [4:0]  out_rd;
  logic        out_wb_ctrl_regWrite;

  int compared = 0;
  int mismatched = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .in_mem_ctrl_memRead (memRead),
    .in_mem_ctrl_memWrite(memWrite),
    .in_mem_ctrl_maskMode(maskMode),
    .in_mem_ctrl_sext    (sext),
    .in_wb_ctrl_toReg    (toReg),
    .in_wb_ctrl_regWrite (regWrite),
    .in_alu_result       (aluResult),
    .in_store_data       (storeData),
    .in_rd               (rdIn),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_be             (dmem_be),
    .dmem_wdata          (dmem_wdata),
    .dmem_ready          (dmem_ready),
    .dmem_rdata          (dmem_rdata),
    .mem_stall           (mem_stall),
    .misalign            (misalign),
    .bus_err             (bus_err),
    .out_wb_data         (out_wb_data),
    .out_rd              (out_rd),
    .out_wb_ctrl_regWrite(out_wb_ctrl_regWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic setOp(input logic r, input logic w, input logic [1:0] m, input logic sx,
                       input logic tr, input logic rw, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] d);
    memRead = r; memWrite = w; maskMode = m; sext = sx; toReg = tr;
    regWrite = rw; aluResult = a; storeData = sd; rdIn = d;
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  // Reference model: byte-level reasoning about access size and offset
  function automatic int accSize(input logic [1:0] m);
    return (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] refBe(input logic [1:0] m, input logic [1:0] off);
    logic [3:0] be;
    int sz = accSize(m);
    for (int i = 0; i < 4; i++) be[i] = (i >= int'(off)) && (i < int'(off) + sz);
    return be;
  endfunction

  function automatic logic [31:0] refWdata(input logic [1:0] m, input logic [31:0] d);
    logic [31:0] v;
    int sz = accSize(m);
    for (int i = 0; i < 4; i++) v[8*i +: 8] = d[8*(i % sz) +: 8];
    return v;
  endfunction

  function automatic logic [31:0] refLoad(input logic [1:0] m, input logic sx,
                                          input logic [1:0] off, input logic [31:0] rd);
    longint val = 0;
    int sz = accSize(m);
    for (int j = 0; j < sz; j++)
      if (int'(off) + j < 4) val += longint'(rd[8*(int'(off)+j) +: 8]) << (8*j);
    if (sx && sz < 4 && val >= (longint'(1) << (8*sz - 1))) val -= (longint'(1) << (8*sz));
    return val[31:0];
  endfunction

  typedef struct {
    string       name;
    logic        r, w;
    logic [1:0]  m;
    logic        sx, tr, rw;
    logic [31:0] addr, sd, rdata;
    logic        ready;
    logic [4:0]  rd;
    logic        eReq, eWe;
    logic [3:0]  eBe;
    logic [31:0] eWdata;
    logic        eMis, eStall;
    logic [31:0] eWb;
    logic        eRw;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"st_byte", 0, 1, 2'd0, 0, 0, 0, 32'h1003, 32'h000000A5, 32'h0, 1, 5'd1,
                     1, 1, 4'b1000, 32'hA5A5A5A5, 0, 0, 32'h1003, 0});
    vecs.push_back('{"ld_half_s", 1, 0, 2'd1, 1, 1, 1, 32'h2002, 32'h0, 32'h80011234, 1, 5'd5,
                     1, 0, 4'b1100, 32'h0, 0, 0, 32'hFFFF8001, 1});
    vecs.push_back('{"ld_half_z", 1, 0, 2'd1, 0, 1, 1, 32'h2002, 32'h0, 32'h80011234, 1, 5'd6,
                     1, 0, 4'b1100, 32'h0, 0, 0, 32'h00008001, 1});
    vecs.push_back('{"ld_word_mis", 1, 0, 2'd2, 0, 1, 1, 32'h3001, 32'h0, 32'h11223344, 0, 5'd7,
                     0, 0, 4'hF, 32'h0, 1, 0, 32'h00112233, 0});
    vecs.push_back('{"alu_op", 0, 0, 2'd2, 0, 0, 1, 32'hDEADBEEF, 32'h0, 32'h0, 0, 5'd9,
                     0, 0, 4'hF, 32'h0, 0, 0, 32'hDEADBEEF, 1});
    vecs.push_back('{"ld_byte_s", 1, 0, 2'd0, 1, 1, 1, 32'h13, 32'h0, 32'h9C000000, 1, 5'd10,
                     1, 0, 4'b1000, 32'h0, 0, 0, 32'hFFFFFF9C, 1});
    vecs.push_back('{"rw_half", 1, 1, 2'd1, 0, 0, 0, 32'h6, 32'h1234ABCD, 32'h0, 1, 5'd11,
                     1, 1, 4'b1100, 32'hABCDABCD, 0, 0, 32'h6, 0});
    vecs.push_back('{"st_mode3", 0, 1, 2'd3, 0, 0, 0, 32'h40, 32'hCAFEF00D, 32'h0, 1, 5'd12,
                     1, 1, 4'hF, 32'hCAFEF00D, 0, 0, 32'h40, 0});
  end

  initial begin
    reset_n = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    setOp(1, 0, 2'd2, 0, 1, 1, 32'h100, 32'h0, 5'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", dmem_req, 0);
    check("rst_stall", mem_stall, 0);
    check("rst_wb", out_wb_data, 0);
    check("rst_rd", out_rd, 0);
    check("rst_rw", out_wb_ctrl_regWrite, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Zero-wait / non-memory vectors
    foreach (vecs[i]) begin
      setOp(vecs[i].r, vecs[i].w, vecs[i].m, vecs[i].sx, vecs[i].tr, vecs[i].rw,
            vecs[i].addr, vecs[i].sd, vecs[i].rd);
      dmem_ready = vecs[i].ready;
      dmem_rdata = vecs[i].rdata;
      @(negedge clk);
      check({vecs[i].name, "_req"}, dmem_req, vecs[i].eReq);
      check({vecs[i].name, "_mis"}, misalign, vecs[i].eMis);
      check({vecs[i].name, "_stall"}, mem_stall, vecs[i].eStall);
      if (vecs[i].eReq) begin
        check({vecs[i].name, "_we"}, dmem_we, vecs[i].eWe);
        check({vecs[i].name, "_be"}, dmem_be, vecs[i].eBe);
        check({vecs[i].name, "_addr"}, dmem_addr, {vecs[i].addr[31:2], 2'b00});
        if (vecs[i].eWe) check({vecs[i].name, "_wdata"}, dmem_wdata, vecs[i].eWdata);
      end
      nextEdge();
      check({vecs[i].name, "_wb"}, out_wb_data, vecs[i].eWb);
      check({vecs[i].name, "_rd"}, out_rd, vecs[i].rd);
      check({vecs[i].name, "_rw"}, out_wb_ctrl_regWrite, vecs[i].eRw);
    end

    // Load word, ready after 3 wait cycles
    setOp(1, 0, 2'd2, 0, 1, 1, 32'h100, 32'h0, 5'd13);
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0BADF00D;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("wait_stall", mem_stall, 1);
      nextEdge();
      check("wait_bubble", out_wb_ctrl_regWrite, 0);
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    check("wait_done_stall", mem_stall, 0);
    nextEdge();
    check("wait_wb", out_wb_data, 32'h0BADF00D);
    check("wait_rd", out_rd, 13);
    check("wait_rw", out_wb_ctrl_regWrite, 1);

    // Back-to-back: ALU op retires on the very next edge
    setOp(0, 0, 2'd0, 0, 0, 1, 32'h00001234, 32'h0, 5'd14);
    dmem_ready = 1'b0;
    nextEdge();
    check("b2b_wb", out_wb_data, 32'h1234);
    check("b2b_rd", out_rd, 14);
    check("b2b_rw", out_wb_ctrl_regWrite, 1);

    // Timeout: no ready at all
    setOp(1, 0, 2'd2, 0, 1, 1, 32'h200, 32'h0, 5'd15);
    dmem_ready = 1'b0;
    for (int c = 0; c < TMO; c++) begin
      @(negedge clk);
      check("tmo_stall", mem_stall, 1);
      check("tmo_noerr", bus_err, 0);
      nextEdge();
    end
    @(negedge clk);
    check("tmo_abort_stall", mem_stall, 0);
    check("tmo_err", bus_err, 1);
    nextEdge();
    check("tmo_rw", out_wb_ctrl_regWrite, 0);
    check("tmo_rd", out_rd, 15);
    setOp(1, 0, 2'd2, 0, 1, 1, 32'h204, 32'h0, 5'd16);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h600DCAFE;
    @(negedge clk);
    check("tmo_idle_stall", mem_stall, 0);
    check("tmo_err_gone", bus_err, 0);
    nextEdge();
    check("tmo_next_wb", out_wb_data, 32'h600DCAFE);
    check("tmo_next_rw", out_wb_ctrl_regWrite, 1);

    // Reset pulled low mid-wait
    setOp(1, 0, 2'd2, 0, 1, 1, 32'h300, 32'h0, 5'd17);
    dmem_ready = 1'b0;
    nextEdge();
    nextEdge();
    @(negedge clk);
    check("rstw_stall_pre", mem_stall, 1);
    #1 reset_n = 1'b0;
    #1;
    check("rstw_req", dmem_req, 0);
    check("rstw_stall", mem_stall, 0);
    check("rstw_wb", out_wb_data, 0);
    check("rstw_rd", out_rd, 0);
    check("rstw_rw", out_wb_ctrl_regWrite, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    setOp(0, 0, 2'd0, 0, 0, 1, 32'h00000777, 32'h0, 5'd18);
    @(negedge clk);
    check("rstw_idle_req", dmem_req, 0);
    nextEdge();
    check("rstw_after_wb", out_wb_data, 32'h777);
    check("rstw_after_rw", out_wb_ctrl_regWrite, 1);

    // Randomized transactions against the reference model
    for (int it = 0; it < 300; it++) begin
      logic        r, w, sx, tr, rw, live, mis, expErr, expRw;
      logic [1:0]  m;
      logic [31:0] a, sd, rdv, expWb;
      logic [4:0]  d;
      int k, expStall, stallSeen, errSeen, cyc;
      bit done;
      r  = 1'($urandom_range(0, 1));
      w  = ($urandom_range(0, 3) == 0);
      m  = 2'($urandom_range(0, 3));
      sx = 1'($urandom_range(0, 1));
      tr = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      sd  = $urandom;
      rdv = $urandom;
      d   = 5'($urandom_range(0, 31));
      k   = $urandom_range(0, TMO + 2);

      mis      = (r | w) && ((int'(a[1:0]) % accSize(m)) != 0);
      live     = (r | w) && !mis;
      expStall = !live ? 0 : (k <= TMO) ? k : TMO;
      expErr   = live && (k > TMO);
      expRw    = rw && !mis && !expErr;
      expWb    = tr ? refLoad(m, sx, a[1:0], rdv) : a;

      setOp(r, w, m, sx, tr, rw, a, sd, d);
      dmem_rdata = rdv;
      dmem_ready = (k == 0);
      stallSeen = 0; errSeen = 0; cyc = 0; done = 0;
      while (!done && cyc < 20) begin
        @(negedge clk);
        if (cyc == 0) begin
          check("rnd_req", dmem_req, live);
          check("rnd_mis", misalign, mis);
          if (live) begin
            check("rnd_we", dmem_we, w);
            check("rnd_be", dmem_be, refBe(m, a[1:0]));
            check("rnd_addr", dmem_addr, a & 32'hFFFF_FFFC);
            if (w) check("rnd_wdata", dmem_wdata, refWdata(m, sd));
          end
        end
        if (mem_stall) stallSeen++;
        if (bus_err) errSeen++;
        done = !mem_stall;
        nextEdge();
        cyc++;
        dmem_ready = (cyc == k);
      end
      check("rnd_stall_cycles", stallSeen, expStall);
      check("rnd_bus_err", errSeen, expErr);
      check("rnd_wb", out_wb_data, expWb);
      check("rnd_rd", out_rd, d);
      check("rnd_rw", out_wb_ctrl_regWrite, expRw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM stage of the 5-stage RISC-V pipeline, directly downstream of the EX/MEM control register. Consumes the registered memory/write-back controls, ALU address and store data. Runs a req/ready transaction on the data-memory bus with byte-lane alignment, load extraction and sign extension, and stalls the pipeline while the bus is busy. Produces a registered MEM/WB bundle (write-back data, rd, regWrite) for the WB stage.

## Interface
- TIMEOUT_CYCLES, 16: maximum bus wait cycles before an access is aborted.
- clk  in  1  pipeline clock
- reset_n  in  1  one clock; reset is asynchronous and active-low
- in_mem_ctrl_memRead  in  1  load request
- in_mem_ctrl_memWrite  in  1  store request
- in_mem_ctrl_maskMode  in  2  0 byte, 1 half, 2 word, 3 treated as word
- in_mem_ctrl_sext  in  1  1 = sign-extend loads, 0 = zero-extend
- in_wb_ctrl_toReg  in  1  1 = write back load data, 0 = ALU result
- in_wb_ctrl_regWrite  in  1  register write enable
- in_alu_result  in  32  effective address / ALU result
- in_store_data  in  32  rs2 value for stores
- in_rd  in  5  destination register
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address ({in_alu_result[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ready  in  1  transaction complete this cycle
- dmem_rdata  in  32  read word, valid with dmem_ready
- mem_stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM
- misalign  out  1  one-cycle pulse: misaligned access rejected
- bus_err  out  1  one-cycle pulse: access timed out
- out_wb_data  out  32  registered write-back data
- out_rd  out  5  registered rd
- out_wb_ctrl_regWrite  out  1  registered write enable

## Operation
- access = memRead | memWrite. Misaligned: half with addr[0]=1, word with addr[1:0]!=0. Misaligned access issues no bus request.
- Store lanes: byte be=4'b0001<<addr[1:0], wdata={4{d[7:0]}}. Half be=4'b0011<<addr[1:0], wdata={2{d[15:0]}}. Word be=4'hF, wdata=d. dmem_we=memWrite. Loads drive be per the same rule.
- Load extract: w = dmem_rdata >> (8*addr[1:0]). Byte: w[7:0], extended to 32 by sext. Half: w[15:0], extended by sext. Word: w.
- FSM IDLE/WAIT:
  - IDLE: aligned access → dmem_req=1. If dmem_ready, complete this cycle. Otherwise go to WAIT with counter=1.
  - WAIT: dmem_req=1. On dmem_ready, complete and return to IDLE. If counter==TIMEOUT_CYCLES with no ready, abort: bus_err=1, return to IDLE. Otherwise counter+1.
- mem_stall = dmem_req & ~dmem_ready & ~abort.
- A memRead and memWrite asserted together are treated as a store.
- MEM/WB register update on each non-stalled edge:
  - out_wb_data = toReg ? extracted load : in_alu_result.
  - out_rd = in_rd.
  - out_wb_ctrl_regWrite = in regWrite & ~misalign & ~abort.
- While stalled, the MEM/WB register loads a bubble (regWrite=0, data/rd hold).

## Timing
- Reset values: all registered outputs 0, FSM IDLE, counter 0. dmem_req, mem_stall, misalign and bus_err are forced 0 while reset_n=0, including mid-transaction.
- Non-memory op or zero-wait access: result appears at out_* one edge after inputs, no stall.
- Each dmem_ready-low cycle adds one stall cycle. The bus must sample addr/be/wdata only while dmem_req=1; they are stable because EX/MEM is frozen.
- Timeout: after TIMEOUT_CYCLES wait cycles, the abort cycle deasserts stall. The instruction retires with regWrite=0.
- The cycle after completion accepts the next access in IDLE (back-to-back, no dead cycle).

## Structure
- Shared package mem_pkg: maskMode encodings (MASK_BYTE/HALF/WORD) and the FSM state enum.
- Sub-module mem_lane_align (combinational): store be/wdata generation and load extract/extend. The top level holds the FSM, timeout counter and MEM/WB register.

## Test plan
- Store byte, addr 0x1003, data 0xA5, ready in same cycle → be=4'b1000, wdata=0xA5A5A5A5, no stall, regWrite out 0.
- Load half sext, addr 0x2002, rdata 0x8001_1234, toReg=1 → out_wb_data=0xFFFF8001, rd propagated; same with sext=0 → 0x00008001.
- Load word, ready after 3 cycles → mem_stall high exactly 3 cycles, bubbles (regWrite=0) meanwhile, then correct data.
- Load word at addr 0x3001 → no dmem_req, misalign pulse, out regWrite 0, no stall.
- ready never asserted, TIMEOUT_CYCLES=4 → stall for 4 cycles, bus_err pulse, regWrite 0, FSM back to IDLE. Repeat with reset_n pulled low in WAIT → req/stall drop immediately, all outputs 0.
- ALU op (no access) back-to-back after a load → both retire on consecutive cycles with correct data.
